// File: rtl/lcd_power_seq_if.sv
// lcd_power_seq_if
//   Groups the request, frame-timing and status signals that pass between the
//   system/timing-driver side and the LCD power sequencer.
//
//   master : system side. Drives disp_on_req, disp_off_req, frame_start,
//            bl_level and observes the sequencer outputs.
//   slave  : the sequencer. Samples the requests and drives lcd_rst, drv_en,
//            lcd_bl, duty, state and ready.
interface lcd_power_seq_if;
  logic       disp_on_req;   // one-cycle pulse: display on
  logic       disp_off_req;  // one-cycle pulse: display off
  logic       frame_start;   // one-cycle pulse at h=0, v=0
  logic [7:0] bl_level;      // target backlight duty

  logic       lcd_rst;       // panel reset, active low
  logic       drv_en;        // timing-driver enable
  logic       lcd_bl;        // backlight PWM
  logic [7:0] duty;          // applied duty
  logic [2:0] state;         // current state code
  logic       ready;         // high only in ON

  modport master (
    output disp_on_req, disp_off_req, frame_start, bl_level,
    input  lcd_rst, drv_en, lcd_bl, duty, state, ready
  );

  modport slave (
    input  disp_on_req, disp_off_req, frame_start, bl_level,
    output lcd_rst, drv_en, lcd_bl, duty, state, ready
  );
endinterface

// File: rtl/lcd_power_seq.sv
// lcd_power_seq
//   Power-up / power-down sequencer and backlight PWM controller for the RGB
//   LCD path. Holds the panel in reset, waits for the panel to settle, lets
//   the timing driver run a few dark frames, then ramps the backlight once
//   per frame. Power-down ramps the backlight to zero and stops the timing
//   driver on a frame boundary.
//
//   Ports:
//     lcd_clk   : pixel clock, the only clock
//     sys_rst_n : asynchronous active-low reset
//     bus       : lcd_power_seq_if.slave (requests, frame_start, bl_level in;
//                 lcd_rst, drv_en, lcd_bl, duty, state, ready out)
//
//   State codes: OFF=0 RST=1 WAIT=2 SYNC=3 RAMP_UP=4 ON=5 RAMP_DN=6 STOP=7
module lcd_power_seq #(
  parameter logic [19:0] T_RST   = 20'd33000,  // cycles lcd_rst held low
  parameter logic [19:0] T_WAIT  = 20'd660000, // cycles from lcd_rst release to drv_en
  parameter logic [3:0]  N_SKIP  = 4'd2,       // dark frames before the ramp
  parameter logic [7:0]  STEP    = 8'd4,       // max duty change per frame
  parameter logic [3:0]  PWM_DIV = 4'd3        // PWM counter advances every PWM_DIV+1 clocks
) (
  input  logic           lcd_clk,
  input  logic           sys_rst_n,
  lcd_power_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_RST     = 3'd1,
    S_WAIT    = 3'd2,
    S_SYNC    = 3'd3,
    S_RAMP_UP = 3'd4,
    S_ON      = 3'd5,
    S_RAMP_DN = 3'd6,
    S_STOP    = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [19:0] r_dly;
  logic [3:0]  r_frames;
  logic [7:0]  r_duty;
  logic [7:0]  w_duty_next;
  logic [3:0]  r_pre;
  logic [7:0]  r_pwm_cnt;
  logic        r_lcd_rst;
  logic        r_drv_en;
  logic        r_lcd_bl;
  logic        r_ready;

  // Request decode: off always wins over a simultaneous on.
  logic w_on;
  logic w_off;
  assign w_off = bus.disp_off_req;
  assign w_on  = bus.disp_on_req & ~bus.disp_off_req;

  // Duty step candidates. The upward sum is 9 bits so a large duty plus STEP
  // cannot wrap past 255 before the clamp to bl_level.
  logic [8:0] w_sum;
  logic [7:0] w_up;        // min(duty + STEP, bl_level)
  logic [7:0] w_down_tgt;  // max(duty - STEP, bl_level), valid when duty > bl_level
  logic [7:0] w_down_zero; // duty <= STEP ? 0 : duty - STEP
  logic [7:0] w_gap;
  logic       w_skip_done;

  assign w_sum       = {1'b0, r_duty} + {1'b0, STEP};
  assign w_up        = (w_sum > {1'b0, bus.bl_level}) ? bus.bl_level : w_sum[7:0];
  assign w_gap       = r_duty - bus.bl_level;
  assign w_down_tgt  = (w_gap <= STEP) ? bus.bl_level : (r_duty - STEP);
  assign w_down_zero = (r_duty <= STEP) ? 8'd0 : (r_duty - STEP);
  // The frame being counted now is the (r_frames+1)-th in SYNC.
  assign w_skip_done = ({1'b0, r_frames} + 5'd1) >= {1'b0, N_SKIP};

  // Next-state and next-duty. A request that causes a transition pre-empts
  // any duty step on a coinciding frame_start.
  always_comb begin
    // NOTE: every output of this block gets a default here so that no path
    // through the case leaves it unassigned, which would infer a latch.
    w_state_next = r_state;
    w_duty_next  = r_duty;
    case (r_state)
      S_OFF: begin
        if (w_on) w_state_next = S_RST;
      end
      S_RST: begin
        if (w_off)                          w_state_next = S_OFF;
        else if (r_dly == T_RST - 20'd1)    w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_off)                          w_state_next = S_OFF;
        else if (r_dly == T_WAIT - 20'd1)   w_state_next = S_SYNC;
      end
      S_SYNC: begin
        if (w_off)                                  w_state_next = S_OFF;
        else if (bus.frame_start && w_skip_done)    w_state_next = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (w_off) begin
          w_state_next = S_RAMP_DN;
        end else if (bus.frame_start) begin
          w_duty_next = w_up;
          // Also covers bl_level == 0 with duty == 0 on the first frame.
          if (w_up == bus.bl_level) w_state_next = S_ON;
        end
      end
      S_ON: begin
        if (w_off) begin
          w_state_next = S_RAMP_DN;
        end else if (bus.frame_start) begin
          if (r_duty < bus.bl_level)      w_duty_next = w_up;
          else if (r_duty > bus.bl_level) w_duty_next = w_down_tgt;
        end
      end
      S_RAMP_DN: begin
        if (w_on) begin
          w_state_next = S_RAMP_UP;
        end else if (bus.frame_start) begin
          w_duty_next = w_down_zero;
          if (w_down_zero == 8'd0) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Hold the driver running until a frame boundary, then shut down.
        if (bus.frame_start) w_state_next = S_OFF;
      end
      default: w_state_next = S_OFF;
    endcase
    if (w_state_next == S_OFF) w_duty_next = 8'd0;
  end

  // State, counters and duty.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_OFF;
      r_dly    <= '0;
      r_frames <= '0;
      r_duty   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_state_next;
      r_duty  <= w_duty_next;

      // Delay counter restarts on every state change.
      if (w_state_next != r_state)
        r_dly <= '0;
      else if (r_state == S_RST || r_state == S_WAIT)
        r_dly <= r_dly + 20'd1;

      if (w_state_next == S_SYNC && r_state != S_SYNC)
        r_frames <= '0;
      else if (r_state == S_SYNC && bus.frame_start)
        r_frames <= r_frames + 4'd1;
    end
  end

  // Registered outputs, decoded from the state being entered so they change
  // on the same edge as state.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_lcd_rst <= 1'b0;
      r_drv_en  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_lcd_rst <= !(w_state_next inside {S_OFF, S_RST});
      r_drv_en  <= (w_state_next inside {S_SYNC, S_RAMP_UP, S_ON, S_RAMP_DN, S_STOP});
      r_ready   <= (w_state_next == S_ON);
    end
  end

  // Free-running PWM: prescaler, 8-bit period counter and compare.
  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
      r_lcd_bl  <= 1'b0;
    end else begin
      if (r_pre == PWM_DIV) begin
        r_pre     <= '0;
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end else begin
        r_pre <= r_pre + 4'd1;
      end
      // Backlight stays dark while the panel is unpowered or settling.
      r_lcd_bl <= (r_pwm_cnt < r_duty) && !(r_state inside {S_OFF, S_RST, S_WAIT});
    end
  end

  assign bus.lcd_rst = r_lcd_rst;
  assign bus.drv_en  = r_drv_en;
  assign bus.lcd_bl  = r_lcd_bl;
  assign bus.duty    = r_duty;
  assign bus.state   = r_state;
  assign bus.ready   = r_ready;

endmodule

// File: tb/tb_lcd_power_seq.sv
// tb_lcd_power_seq
//   Directed power-up / power-down / PWM / reset scenarios followed by a
//   randomized run. A behavioural model tracks the expected outputs from the
//   sequencing rules (entry timestamps, frame tallies, duty arithmetic) and a
//   compare process checks every DUT output against it on each falling edge.
module tb_lcd_power_seq;

  localparam int P_T_RST   = 10;
  localparam int P_T_WAIT  = 20;
  localparam int P_N_SKIP  = 2;
  localparam int P_STEP    = 4;
  localparam int P_PWM_DIV = 0;

  logic lcd_clk;
  logic sys_rst_n;

  lcd_power_seq_if bus ();

  lcd_power_seq #(
    .T_RST  (20'(P_T_RST)),
    .T_WAIT (20'(P_T_WAIT)),
    .N_SKIP (4'(P_N_SKIP)),
    .STEP   (8'(P_STEP)),
    .PWM_DIV(4'(P_PWM_DIV))
  ) dut (
    .lcd_clk  (lcd_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial lcd_clk = 1'b0;
  always #5 lcd_clk = ~lcd_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Timing is tracked as "edge index when the state was entered" rather than
  // a running counter; PWM position is derived from the edge count.
  typedef struct {
    int st;      // state code
    int duty;
    int bl;      // lcd_bl
    int n;       // edges since reset release
    int entry;   // edge index at which st was entered
    int frames;  // frame_start pulses seen in SYNC
  } model_t;

  model_t m;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  function automatic model_t model_next(input model_t c, input bit on, input bit off,
                                        input bit fs, input int lvl);
    model_t r;
    int     ns;
    int     pwm;
    r   = c;
    ns  = c.st;
    pwm = (c.n / (P_PWM_DIV + 1)) % 256;
    r.n = c.n + 1;
    r.bl = ((pwm < c.duty) && (c.st >= 3)) ? 1 : 0;
    case (c.st)
      0: if (on && !off) ns = 1;
      1: if (off) ns = 0; else if (r.n - c.entry == P_T_RST)  ns = 2;
      2: if (off) ns = 0; else if (r.n - c.entry == P_T_WAIT) ns = 3;
      3: if (off) ns = 0;
         else if (fs) begin
           r.frames = c.frames + 1;
           if (r.frames >= P_N_SKIP) ns = 4;
         end
      4: if (off) ns = 6;
         else if (fs) begin
           r.duty = imin(c.duty + P_STEP, lvl);
           if (r.duty == lvl) ns = 5;
         end
      5: if (off) ns = 6;
         else if (fs) begin
           if (c.duty < lvl)      r.duty = imin(c.duty + P_STEP, lvl);
           else if (c.duty > lvl) r.duty = imax(c.duty - P_STEP, lvl);
         end
      6: if (on && !off) ns = 4;
         else if (fs) begin
           r.duty = (c.duty <= P_STEP) ? 0 : c.duty - P_STEP;
           if (r.duty == 0) ns = 7;
         end
      default: if (fs) ns = 0;
    endcase
    if (ns != c.st) begin
      r.entry = r.n;
      if (ns == 3) r.frames = 0;
    end
    r.st = ns;
    return r;
  endfunction

  function automatic logic [14:0] pack_model(input model_t c);
    return {3'(c.st), (c.st >= 2), (c.st >= 3), c.bl[0], (c.st == 5), 8'(c.duty)};
  endfunction

  function automatic logic [14:0] pack_dut();
    return {bus.state, bus.lcd_rst, bus.drv_en, bus.lcd_bl, bus.ready, bus.duty};
  endfunction

  always @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) m <= '{default: 0};
    else            m <= model_next(m, bus.disp_on_req, bus.disp_off_req,
                                    bus.frame_start, int'(bus.bl_level));
  end

  always @(negedge lcd_clk) begin
    if (sys_rst_n) check("cycle", 32'(pack_dut()), 32'(pack_model(m)));
  end

  // ---------------------------------------------------------------- driver
  int frame_per = 100;
  int fcnt      = 0;
  bit fs_rand   = 1'b0;
  bit last_fs;
  int wcyc;
  int dq[$];

  task automatic cycle(input bit on, input bit off);
    bit fs;
    if (fs_rand) begin
      fs = ($urandom_range(0, 11) == 0);
    end else begin
      fs   = (fcnt == frame_per - 1);
      fcnt = fs ? 0 : fcnt + 1;
    end
    bus.disp_on_req  = on;
    bus.disp_off_req = off;
    bus.frame_start  = fs;
    last_fs          = fs;
    @(negedge lcd_clk);
  endtask

  function automatic int sig(input int w);
    case (w)
      0:       return int'(bus.lcd_rst);
      1:       return int'(bus.drv_en);
      2:       return int'(bus.ready);
      3:       return int'(bus.duty);
      default: return int'(bus.state);
    endcase
  endfunction

  // Idle until the selected output equals val; wcyc returns the edges taken.
  task automatic wait_for(input string name, input int w, input int val, input int budget);
    wcyc = 0;
    while (sig(w) != val && wcyc < budget) begin
      cycle(1'b0, 1'b0);
      wcyc++;
    end
    check(name, sig(w), val);
  endtask

  // Record each new duty value until state reaches stop_state.
  task automatic collect_duty(input int stop_state, input int budget);
    int last;
    int n;
    dq.delete();
    last = int'(bus.duty);
    n    = 0;
    while (int'(bus.state) != stop_state && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
      if (int'(bus.duty) != last) begin
        last = int'(bus.duty);
        dq.push_back(last);
      end
    end
  endtask

  task automatic count_bl(input string name, input int exp_high);
    int hi;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 1'b0);
      hi += int'(bus.lcd_bl);
    end
    check(name, hi, exp_high);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int exp_up[3];
    int exp_dn[3];
    exp_up = '{4, 8, 10};
    exp_dn = '{6, 2, 0};

    sys_rst_n        = 1'b0;
    bus.disp_on_req  = 1'b0;
    bus.disp_off_req = 1'b0;
    bus.frame_start  = 1'b0;
    bus.bl_level     = 8'd10;
    repeat (3) @(negedge lcd_clk);
    check("reset_outputs", 32'(pack_dut()), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);
    check("idle_off", 32'(pack_dut()), 32'd0);

    // Power-on: RST 10 cycles, WAIT 20 cycles, 2 dark frames, duty 4,8,10.
    cycle(1'b1, 1'b0);
    check("enter_rst", sig(4), 1);
    wait_for("lcd_rst_rise", 0, 1, 50);
    check("rst_length", wcyc, P_T_RST);
    wait_for("drv_en_rise", 1, 1, 100);
    check("wait_length", wcyc, P_T_WAIT);
    collect_duty(5, 1000);
    for (int i = 0; i < 3; i++)
      check("ramp_up_duty", (i < dq.size()) ? dq[i] : 999, exp_up[i]);
    check("ramp_up_steps", dq.size(), 3);
    check("ready_at_10", {sig(2), sig(3)}, {32'd1, 32'd10});
    check("model_on_duty", m.duty, 10);

    // Power-off from ON: duty 6,2,0 then drv_en falls after next frame.
    cycle(1'b0, 1'b1);
    check("off_to_ramp_dn", sig(4), 6);
    collect_duty(7, 1000);
    for (int i = 0; i < 3; i++)
      check("ramp_dn_duty", (i < dq.size()) ? dq[i] : 999, exp_dn[i]);
    wait_for("drv_en_fall", 1, 0, 300);
    check("fall_after_frame", int'(last_fs), 1);
    check("off_after_stop", 32'(pack_dut()), 32'd0);

    // Off during WAIT aborts; a new on request restarts full RST timing.
    cycle(1'b1, 1'b0);
    wait_for("wait_entry", 0, 1, 50);
    repeat (3) cycle(1'b0, 1'b0);
    check("still_wait", sig(4), 2);
    cycle(1'b0, 1'b1);
    check("abort_wait", 32'(pack_dut()), 32'd0);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    wait_for("restart_rst_rise", 0, 1, 50);
    check("restart_rst_length", wcyc, P_T_RST);
    wait_for("restart_ready", 2, 1, 2000);

    // Simultaneous on+off in ON, then on in RAMP_DN at duty 6.
    cycle(1'b1, 1'b1);
    check("both_req_on", sig(4), 6);
    wait_for("dn_to_6", 3, 6, 300);
    cycle(1'b1, 1'b0);
    check("redo_ramp_up", {sig(4), sig(3)}, {32'd4, 32'd6});
    wait_for("climb_ready", 2, 1, 500);
    check("climb_duty", sig(3), 10);

    // PWM duty checks (prescale 0: one PWM step per clock).
    frame_per = 20;
    fcnt      = 0;
    bus.bl_level = 8'd0;
    wait_for("duty_to_0", 3, 0, 300);
    count_bl("pwm_duty_0", 0);
    bus.bl_level = 8'd128;
    wait_for("duty_to_128", 3, 128, 2000);
    count_bl("pwm_duty_128", 128);
    bus.bl_level = 8'd255;
    wait_for("duty_to_255", 3, 255, 2000);
    count_bl("pwm_duty_255", 255);

    // Asynchronous reset in ON at duty 200.
    bus.bl_level = 8'd200;
    wait_for("duty_to_200", 3, 200, 2000);
    check("on_at_200", sig(4), 5);
    bus.disp_on_req  = 1'b0;
    bus.disp_off_req = 1'b0;
    bus.frame_start  = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1 check("async_reset", 32'(pack_dut()), 32'd0);
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;

    // Randomized run; the compare process checks every cycle.
    fs_rand = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      bit on;
      bit off;
      on  = ($urandom_range(0, 39) == 0);
      off = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 999) == 0) begin
        on  = 1'b1;
        off = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) bus.bl_level = 8'($urandom_range(0, 255));
      cycle(on, off);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
